// File: rtl/board_state.sv
// board_state: authoritative Connect Four board register.
//
// Holds the 6x7 grid, per-column piece counts and side-to-move. Human drops
// and minimax moves are committed here, after which a fixed 42-cycle scan
// looks for four-in-a-row for the side that just moved, then either hands the
// turn over or ends the game (win, draw, or illegal AI move).
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   col_sel, drop   human column choice (0..6) and level drop request
//   move, opt       minimax done flag and chosen cell bit index
//   grid            98-bit board, cell (r,c) = grid[r*14+13-2c -: 2]
//                   00 empty, 01 human, 10 AI; row 6 is always zero
//   column_counts   3 bits per column, column c at [c*3+2 -: 3]
//   player          1 = AI to move (enables minimax)
//   busy            commit/scan in progress
//   winner          00 none, 01 human, 10 AI
//   game_over       sticky until rst
//   draw            board full without a winner
//   ai_fault        sticky, an illegal opt was presented
module board_state #(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  col_sel,
  input  logic        drop,
  input  logic        move,
  input  logic [6:0]  opt,
  output logic [97:0] grid,
  output logic [20:0] column_counts,
  output logic        player,
  output logic        busy,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic        draw,
  output logic        ai_fault
);

  localparam logic [1:0] S_HUMAN = 2'd0;
  localparam logic [1:0] S_AI    = 2'd1;
  localparam logic [1:0] S_SCAN  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  logic [97:0] grid_q, grid_d;
  logic [20:0] counts_q, counts_d;
  logic [5:0]  pieces_q, pieces_d;
  logic [5:0]  scan_idx_q, scan_idx_d;
  logic [1:0]  state_q, state_d;
  logic [1:0]  winner_q, winner_d;
  logic        player_q, player_d;
  logic        busy_q, busy_d;
  logic        game_over_q, game_over_d;
  logic        draw_q, draw_d;
  logic        ai_fault_q, ai_fault_d;
  logic        mover_q, mover_d;   // 0 = human, 1 = AI
  logic        found_q, found_d;

  // Two-bit cell at (r,c); callers guarantee r,c are in range.
  function automatic logic [1:0] cell_get(input logic [97:0] g, input int r,
                                          input int c);
    return 2'(g >> (r * 14 + 12 - 2 * c));
  endfunction

  // True when cell k starts an in-bounds run of four matching 'code' in
  // any of the directions +c, +r, +r+c, +r-c.
  function automatic logic cell_hit(input logic [97:0] g, input int k,
                                    input logic [1:0] code);
    int   r, c, rr, cc, dr, dc;
    logic any, all;
    r   = k / 7;
    c   = k % 7;
    any = 1'b0;
    for (int d = 0; d < 4; d++) begin
      dr  = (d == 0) ? 0 : 1;
      dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      all = 1'b1;
      for (int i = 0; i < 4; i++) begin
        rr = r + i * dr;
        cc = c + i * dc;
        if (rr < 0 || rr > 5 || cc < 0 || cc > 6) begin
          all = 1'b0;
        end else if (cell_get(g, rr, cc) != code) begin
          all = 1'b0;
        end
      end
      any = any | all;
    end
    return any;
  endfunction

  // Move decode
  logic [2:0] hum_cnt;
  logic       hum_ok;
  logic [6:0] ai_rem, ai_row, ai_col;
  logic [2:0] ai_cnt;
  logic       ai_ok;

  always_comb begin
    hum_cnt = '0;
    for (int c = 0; c < 7; c++) begin
      if (col_sel == 3'(c)) hum_cnt = counts_q[c*3 +: 3];
    end
    hum_ok = drop && (col_sel != 3'd7) && (hum_cnt < 3'd6);

    // opt points at the high bit of a cell, so a legal index is odd and
    // lands on the next free row of its column.
    ai_rem = opt % 7'd14;
    ai_row = opt / 7'd14;
    ai_col = (7'd13 - ai_rem) >> 1;
    ai_cnt = '0;
    for (int c = 0; c < 7; c++) begin
      if (ai_col == 7'(c)) ai_cnt = counts_q[c*3 +: 3];
    end
    ai_ok = ai_rem[0] && (opt < 7'd84) && (ai_row == {4'b0, ai_cnt});
  end

  // Scan evaluation of the current cell
  logic [1:0] mover_code;
  logic       hit;

  always_comb begin
    mover_code = mover_q ? 2'b10 : 2'b01;
    hit        = 1'b0;
    for (int k = 0; k < 42; k++) begin
      if (scan_idx_q == 6'(k)) hit = cell_hit(grid_q, k, mover_code);
    end
  end

  // Next-state logic
  logic       wr_en;
  logic [2:0] wr_row, wr_col;
  logic [1:0] wr_code;

  always_comb begin
    grid_d      = grid_q;
    counts_d    = counts_q;
    pieces_d    = pieces_q;
    scan_idx_d  = scan_idx_q;
    state_d     = state_q;
    winner_d    = winner_q;
    player_d    = player_q;
    busy_d      = busy_q;
    game_over_d = game_over_q;
    draw_d      = draw_q;
    ai_fault_d  = ai_fault_q;
    mover_d     = mover_q;
    found_d     = found_q;
    wr_en       = 1'b0;
    wr_row      = '0;
    wr_col      = '0;
    wr_code     = '0;

    case (state_q)
      S_HUMAN: begin
        if (hum_ok) begin
          wr_en      = 1'b1;
          wr_row     = hum_cnt;
          wr_col     = col_sel;
          wr_code    = 2'b01;
          busy_d     = 1'b1;
          mover_d    = 1'b0;
          scan_idx_d = '0;
          found_d    = 1'b0;
          state_d    = S_SCAN;
        end
      end
      S_AI: begin
        if (move) begin
          // Dropping player here also releases minimax, so a held move
          // flag cannot commit twice.
          player_d = 1'b0;
          if (ai_ok) begin
            wr_en      = 1'b1;
            wr_row     = ai_cnt;
            wr_col     = ai_col[2:0];
            wr_code    = 2'b10;
            busy_d     = 1'b1;
            mover_d    = 1'b1;
            scan_idx_d = '0;
            found_d    = 1'b0;
            state_d    = S_SCAN;
          end else begin
            ai_fault_d  = 1'b1;
            game_over_d = 1'b1;
            state_d     = S_OVER;
          end
        end
      end
      S_SCAN: begin
        // Always runs all 42 cells so the turn hand-over latency is fixed.
        found_d    = found_q | hit;
        scan_idx_d = scan_idx_q + 6'd1;
        if (scan_idx_q == 6'd41) begin
          busy_d = 1'b0;
          if (found_q | hit) begin
            winner_d    = mover_code;
            game_over_d = 1'b1;
            state_d     = S_OVER;
          end else if (pieces_q == 6'd42) begin
            draw_d      = 1'b1;
            game_over_d = 1'b1;
            state_d     = S_OVER;
          end else if (!mover_q) begin
            player_d = 1'b1;
            state_d  = S_AI;
          end else begin
            state_d = S_HUMAN;
          end
        end
      end
      default: begin
        // S_OVER: hold everything until reset
      end
    endcase

    if (wr_en) begin
      for (int r = 0; r < 6; r++) begin
        for (int c = 0; c < 7; c++) begin
          if (wr_row == 3'(r) && wr_col == 3'(c)) begin
            grid_d[r*14 + 12 - 2*c +: 2] = wr_code;
          end
        end
      end
      for (int c = 0; c < 7; c++) begin
        if (wr_col == 3'(c)) counts_d[c*3 +: 3] = counts_q[c*3 +: 3] + 3'd1;
      end
      pieces_d = pieces_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grid_q      <= '0;
      counts_q    <= '0;
      pieces_q    <= '0;
      scan_idx_q  <= '0;
      state_q     <= FIRST_PLAYER ? S_AI : S_HUMAN;
      winner_q    <= '0;
      player_q    <= FIRST_PLAYER;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      draw_q      <= 1'b0;
      ai_fault_q  <= 1'b0;
      mover_q     <= 1'b0;
      found_q     <= 1'b0;
    end else begin
      grid_q      <= grid_d;
      counts_q    <= counts_d;
      pieces_q    <= pieces_d;
      scan_idx_q  <= scan_idx_d;
      state_q     <= state_d;
      winner_q    <= winner_d;
      player_q    <= player_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
      draw_q      <= draw_d;
      ai_fault_q  <= ai_fault_d;
      mover_q     <= mover_d;
      found_q     <= found_d;
    end
  end

  assign grid          = grid_q;
  assign column_counts = counts_q;
  assign player        = player_q;
  assign busy          = busy_q;
  assign winner        = winner_q;
  assign game_over     = game_over_q;
  assign draw          = draw_q;
  assign ai_fault      = ai_fault_q;

endmodule

// File: tb/tb_board_state.sv
module tb_board_state;

  logic        clk;
  logic        rst;
  logic [2:0]  col_sel;
  logic        drop;
  logic        move;
  logic [6:0]  opt;
  logic [97:0] grid;
  logic [20:0] column_counts;
  logic        player;
  logic        busy;
  logic [1:0]  winner;
  logic        game_over;
  logic        draw;
  logic        ai_fault;

  board_state #(.FIRST_PLAYER(1'b0)) dut (
    .clk(clk), .rst(rst), .col_sel(col_sel), .drop(drop), .move(move),
    .opt(opt), .grid(grid), .column_counts(column_counts), .player(player),
    .busy(busy), .winner(winner), .game_over(game_over), .draw(draw),
    .ai_fault(ai_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: board as a 2-D array of owners (0 empty, 1 human, 2 AI)
  int   m_b [6][7];
  int   m_h [7];
  int   m_pieces;
  int   m_mode;      // 0 human turn, 1 AI turn, 2 checking, 3 finished
  int   m_left;      // checking cycles remaining
  int   m_mover;
  bit   m_win;
  bit   m_player, m_busy, m_go, m_draw, m_fault;
  logic [1:0] m_winner;

  task automatic check(input string tag, input logic [97:0] got,
                       input logic [97:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit has_four(input int p);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        for (int d = 0; d < 4; d++) begin
          bit ok = 1;
          for (int i = 0; i < 4; i++) begin
            int rr = r + i * dr[d];
            int cc = c + i * dc[d];
            if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 0;
            else if (m_b[rr][cc] != p) ok = 0;
          end
          if (ok) return 1;
        end
    return 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 6; r++) for (int c = 0; c < 7; c++) m_b[r][c] = 0;
    for (int c = 0; c < 7; c++) m_h[c] = 0;
    m_pieces = 0; m_mode = 0; m_left = 0; m_mover = 1; m_win = 0;
    m_player = 0; m_busy = 0; m_go = 0; m_draw = 0; m_fault = 0;
    m_winner = 2'b00;
  endtask

  task automatic place(input int p, input int c);
    m_b[m_h[c]][c] = p;
    m_h[c]++;
    m_pieces++;
    m_mover = p;
    m_win = has_four(p);
    m_busy = 1;
    m_player = 0;
    m_left = 42;
    m_mode = 2;
  endtask

  task automatic model_step(input bit r, input bit d, input int cs,
                            input bit mv, input int op);
    if (r) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: if (d && cs < 7 && m_h[cs] < 6) place(1, cs);
      1: if (mv) begin
        int row = op / 14;
        int rem = op % 14;
        int col = (13 - rem) / 2;
        if (rem % 2 == 1 && op < 84 && row == m_h[col]) place(2, col);
        else begin
          m_fault = 1; m_go = 1; m_player = 0; m_mode = 3;
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          if (m_win) begin
            m_winner = 2'(m_mover); m_go = 1; m_mode = 3;
          end else if (m_pieces == 42) begin
            m_draw = 1; m_go = 1; m_mode = 3;
          end else if (m_mover == 1) begin
            m_player = 1; m_mode = 1;
          end else begin
            m_mode = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    logic [97:0] eg;
    logic [20:0] ec;
    eg = '0;
    for (int r = 5; r >= 0; r--)
      for (int c = 0; c < 7; c++) eg = {eg[95:0], 2'(m_b[r][c])};
    ec = '0;
    for (int c = 6; c >= 0; c--) ec = {ec[17:0], 3'(m_h[c])};
    check("grid", grid, eg);
    check("column_counts", 98'(column_counts), 98'(ec));
    check("player", 98'(player), 98'(m_player));
    check("busy", 98'(busy), 98'(m_busy));
    check("winner", 98'(winner), 98'(m_winner));
    check("game_over", 98'(game_over), 98'(m_go));
    check("draw", 98'(draw), 98'(m_draw));
    check("ai_fault", 98'(ai_fault), 98'(m_fault));
  endtask

  task automatic cyc(input bit r, input bit d, input int cs, input bit mv,
                     input int op);
    rst = r; drop = d; col_sel = 3'(cs); move = mv; opt = 7'(op);
    @(posedge clk);
    model_step(r, d, cs, mv, op);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0);
  endtask

  task automatic human(input int c);
    cyc(0, 1, c, 0, 0);
    idle(42);
  endtask

  // AI commit with move held high through the whole check period
  task automatic ai(input int op);
    for (int i = 0; i < 43; i++) cyc(0, 0, 0, 1, op);
  endtask

  initial begin
    rst = 1'b1; drop = 1'b0; col_sel = '0; move = 1'b0; opt = '0;
    model_reset();
    do_reset();
    do_reset();
    idle(3);

    // Single drop then AI reply in the same column
    human(3);
    ai(21);
    idle(2);

    // Human vertical four in column 0, AI stacking column 6
    do_reset();
    human(0); ai(1);
    human(0); ai(15);
    human(0); ai(29);
    human(0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 3);
    idle(2);

    // Fill column 2, then try dropping into it and using col_sel = 7
    do_reset();
    human(2); ai(23);
    human(2); ai(51);
    human(2); ai(79);
    cyc(0, 1, 2, 0, 0);
    cyc(0, 1, 7, 0, 0);
    idle(2);

    // Illegal (even) AI index
    do_reset();
    human(0);
    cyc(0, 0, 0, 1, 20);
    idle(3);

    // Reset in the middle of a check period
    do_reset();
    human(4);
    cyc(0, 1, 4, 0, 0);
    idle(10);
    do_reset();
    idle(3);

    // Randomized games
    for (int g = 0; g < 12; g++) begin
      do_reset();
      for (int t = 0; t < 2200 && !m_go; t++) begin
        bit r, d, mv;
        int cs, op;
        r  = ($urandom % 3000) == 0;
        d  = ($urandom % 4) == 0;
        cs = $urandom % 8;
        mv = ($urandom % 3) == 0;
        op = $urandom % 128;
        if ($urandom % 20 != 0) begin
          int start = $urandom % 7;
          for (int k = 0; k < 7; k++) begin
            int c = (start + k) % 7;
            if (m_h[c] < 6) begin
              op = m_h[c] * 14 + 13 - 2 * c;
              break;
            end
          end
        end
        cyc(r, d, cs, mv, op);
      end
      idle(3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/board_state.md
Name: board_state

Overview:
- Authoritative Connect Four board register for the game datapath, directly upstream of the AI minimax stage.
- Drives grid, column_counts and player into minimax, and consumes its opt/move result to commit the AI's piece.
- Accepts human drops, commits AI moves, then runs a fixed-latency sequential four-in-a-row/draw scan before handing the turn over.

Parameters:
FIRST_PLAYER  0  side to move after reset: 0 = human, 1 = AI

Ports:
clk            in   1   system clock
rst            in   1   reset
col_sel        in   3   human column choice, 0..6
drop           in   1   human drop request, sampled every edge (level, debounced upstream)
move           in   1   minimax done flag
opt            in   7   minimax chosen cell bit index (high bit of the 2-bit cell)
grid           out  98  board; cell (r,c) = grid[r*14+13-2c -: 2]; 00 empty, 01 human, 10 AI
column_counts  out  21  pieces per column; col c = column_counts[c*3+2 -: 3], 0..6
player         out  1   1 = AI to move (enables minimax), 0 otherwise
busy           out  1   commit/scan in progress
winner         out  2   00 none, 01 human, 10 AI
game_over      out  1   sticky until rst
draw           out  1   board full, no winner
ai_fault       out  1   sticky; illegal opt was presented

Behaviour:
- Single clock clk. rst is synchronous, active-high.
- Reset values:
  - grid = 0, column_counts = 0, piece counter = 0, player = FIRST_PLAYER.
  - busy, winner, game_over, draw, ai_fault all 0.
  - State = HUMAN if FIRST_PLAYER = 0, else AI.
- Board geometry: 6 rows used (r = 0 is the bottom). Row 6 (grid[97:84]) is always 0.
- Cell index k = 0..41 maps to r = k/7, c = k%7.
- States: HUMAN, AI, SCAN, OVER.
- HUMAN state (player = 0):
  - Drop is accepted at edge N when drop = 1, col_sel < 7 and column_counts[col_sel] < 6.
  - At edge N: write 01 to cell (count, col_sel), increment that column count, increment the piece counter.
  - Also at edge N: busy <= 1, mover <= human, scan_idx <= 0, state <= SCAN.
  - Drop with col_sel = 7, or into a full column: ignored, no register changes.
  - move is ignored in this state.
- AI state (player = 1):
  - Commit happens on the first edge with move = 1. Decode col = (13 - opt%14)/2 and row = opt/14.
  - Legal when opt%14 is odd, opt < 84, and row == column_counts[col].
  - Legal opt: write 10 to cell (row, col), update counts as for a human drop, set player <= 0 at the same edge, enter SCAN.
  - Dropping player to 0 clears minimax, so move is never double-counted.
  - Illegal opt: ai_fault <= 1, game_over <= 1, player <= 0, state <= OVER, grid unchanged.
  - drop is ignored in this state.
- SCAN state:
  - busy = 1 and player = 0 throughout.
  - Edges N+1..N+42 each evaluate cell scan_idx, then increment it.
  - A hit requires the cell and the next 3 cells all equal the mover's code, in-bounds, in any of 4 directions: +c, +r, +r+c, +r-c.
  - Any hit sets a sticky found flag. There is no early exit: latency is fixed at 42 scan cycles.
  - At edge N+42, if found: winner <= mover, game_over <= 1, state <= OVER.
  - Else if the piece counter = 42: draw <= 1, game_over <= 1, state <= OVER.
  - Otherwise, after a human move: player <= 1, state <= AI. After an AI move: player stays 0, state <= HUMAN.
  - busy <= 0 at edge N+42 in every case.
- OVER state: player = 0, busy = 0, all inputs ignored; only rst exits.
- Inputs during SCAN are ignored; nothing is queued.
- rst at any edge, including mid-scan, takes priority and restores reset values on that edge.
- Width rules:
  - Column counts saturate logically at 6 because full columns are never written.
  - The piece counter is 6 bits.
  - The opt decode uses a 7-bit modulo; no value ≥ 98 is legal.

Test Plan:
- Reset with FIRST_PLAYER = 0 -> grid = 0, column_counts = 0, player = 0, all flags 0.
- Drop col_sel = 3 -> next edge grid[7:6] = 01 and column_counts[11:9] = 1; busy high exactly 42 cycles after the commit edge; then player = 1.
- In AI state, opt = 21, move = 1 -> grid[21:20] = 10, column_counts[11:9] = 2, player = 0 at the commit edge; after scan, state HUMAN; holding move high afterwards causes no second write.
- Human vertical four:
  - Stimulus: drops in col 0 interleaved with AI opt = 1, 15, 29 (col 6).
  - After the 4th human drop's scan: winner = 01, game_over = 1.
  - A subsequent drop leaves grid unchanged.
- Fill column 2 (6 pieces), then drop col 2 in HUMAN -> no change, busy stays 0. col_sel = 7 is also ignored.
- AI opt = 20 (even index) -> ai_fault = 1, game_over = 1, grid unchanged.
- Separately, rst asserted mid-scan -> all reset values next edge.
